// File: rtl/wasm_stack_pkg.sv
// Shared opcode, FSM state and trap-code definitions for the WASM operand-stack sequencer.
package wasm_stack_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_CONST = 4'h1;
    localparam logic [3:0] OP_DROP  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_EQZ   = 4'h8;
    localparam logic [3:0] OP_EQ    = 4'h9;
    localparam logic [3:0] OP_LT_S  = 4'hA;
    localparam logic [3:0] OP_LT_U  = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH2 = 3'd1,
        ST_EXEC   = 3'd2,
        ST_POP    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_UNDER   = 2'd1;
    localparam logic [1:0] TRAP_OVER    = 2'd2;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd3;

    // Two-operand ops consume second and top and leave one result.
    function automatic logic is_binary(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_XOR)) || ((op >= OP_EQ) && (op <= OP_SHL));
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational i32 ALU: a is the deeper stack word, b the top word.
module stack_alu
    import wasm_stack_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_EQZ:  result = (b == '0) ? ONE : '0;
            OP_EQ:   result = (a == b) ? ONE : '0;
            OP_LT_S: result = ($signed(a) < $signed(b)) ? ONE : '0;
            OP_LT_U: result = (a < b) ? ONE : '0;
            OP_SHL:  result = a << b[SHW-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_exec.sv
// Operand-stack execution sequencer: accepts one opcode at a time (valid/ready) and drives
// single-command steps into the BRAM stack; faults are sticky until reset.
module stack_exec
    import wasm_stack_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // Handshake: an opcode transfers on a rising edge where op_valid && op_ready.
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            op_code,
    input  logic [WIDTH-1:0]      op_imm,
    output logic                  stk_push,
    output logic [WIDTH-1:0]      stk_push_data,
    output logic                  stk_pop,
    output logic                  stk_read_second,
    output logic                  stk_write_top,
    output logic                  stk_write_second,
    output logic [WIDTH-1:0]      stk_write_data,
    input  logic [WIDTH-1:0]      stk_top,
    input  logic [WIDTH-1:0]      stk_second,
    input  logic [DEPTH_LOG2-1:0] stk_depth,
    output logic                  trap,
    output logic [1:0]            trap_code,
    output logic                  retired,
    output logic [2:0]            dbg_state
);

    localparam logic [DEPTH_LOG2-1:0] DEPTH_FULL = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] DEPTH_TWO  = DEPTH_LOG2'(2);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [1:0]       trap_code_q, trap_code_d;
    logic [1:0]       check_code;
    logic [WIDTH-1:0] alu_result;

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (stk_second),
        .b      (stk_top),
        .result (alu_result)
    );

    // Legality of the offered opcode against the current stack depth.
    always_comb begin
        check_code = TRAP_NONE;
        if (op_code > OP_SHL) begin
            check_code = TRAP_ILLEGAL;
        end else if (is_binary(op_code)) begin
            if (stk_depth < DEPTH_TWO) check_code = TRAP_UNDER;
        end else if ((op_code == OP_DROP) || (op_code == OP_EQZ)) begin
            if (stk_depth == '0) check_code = TRAP_UNDER;
        end else if (op_code == OP_CONST) begin
            if (stk_depth == DEPTH_FULL) check_code = TRAP_OVER;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        trap_code_d = trap_code_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d  = op_code;
                    imm_d = op_imm;
                    if (check_code != TRAP_NONE) begin
                        state_d     = ST_TRAP;
                        trap_code_d = check_code;
                    end else if (is_binary(op_code)) begin
                        state_d = ST_FETCH2;
                    end else if (op_code == OP_EQZ) begin
                        state_d = ST_EXEC;
                    end else if ((op_code == OP_CONST) || (op_code == OP_DROP)) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_FETCH2: state_d = ST_EXEC;
            ST_EXEC:   state_d = is_binary(op_q) ? ST_POP : ST_SETTLE;
            ST_POP:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            imm_q       <= '0;
            trap_code_q <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            trap_code_q <= trap_code_d;
        end
    end

    // Every command line is decoded from the registered state and latched opcode only.
    always_comb begin
        op_ready         = (state_q == ST_IDLE);
        retired          = (state_q == ST_SETTLE);
        trap             = (state_q == ST_TRAP);
        trap_code        = trap_code_q;
        stk_read_second  = (state_q == ST_FETCH2);
        stk_write_second = (state_q == ST_EXEC) && is_binary(op_q);
        stk_write_top    = (state_q == ST_EXEC) && (op_q == OP_EQZ);
        stk_write_data   = (state_q == ST_EXEC) ? alu_result : '0;
        // The POP slot doubles as the push step for CONST.
        stk_push         = (state_q == ST_POP) && (op_q == OP_CONST);
        stk_pop          = (state_q == ST_POP) && (op_q != OP_CONST);
        stk_push_data    = stk_push ? imm_q : '0;
        dbg_state        = state_q;
    end

endmodule

// File: tb/tb_stack_exec.sv
// Bench for stack_exec: a behavioural BRAM stack feeds the DUT; results are checked against
// directed vector tables, hand sequences and a queue-based reference model.
module tb_stack_exec;
    import wasm_stack_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           op_valid = 1'b0;
    logic [3:0]     op_code = 4'h0;
    logic [W-1:0]   op_imm = '0;
    logic           op_ready, stk_push, stk_pop, stk_read_second, stk_write_top, stk_write_second;
    logic [W-1:0]   stk_push_data, stk_write_data, stk_top, stk_second;
    logic [4:0]     stk_depth;
    logic           trap, retired;
    logic [1:0]     trap_code;
    logic [2:0]     dbg_state;

    always #5 clk = ~clk;

    stack_exec #(.DEPTH_LOG2(5), .WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_code          (op_code),
        .op_imm           (op_imm),
        .stk_push         (stk_push),
        .stk_push_data    (stk_push_data),
        .stk_pop          (stk_pop),
        .stk_read_second  (stk_read_second),
        .stk_write_top    (stk_write_top),
        .stk_write_second (stk_write_second),
        .stk_write_data   (stk_write_data),
        .stk_top          (stk_top),
        .stk_second       (stk_second),
        .stk_depth        (stk_depth),
        .trap             (trap),
        .trap_code        (trap_code),
        .retired          (retired),
        .dbg_state        (dbg_state)
    );

    // Behavioural BRAM stack: depth updates at once, top refreshes one cycle later,
    // second refreshes only on read_second.
    logic [W-1:0] mem [0:31];
    logic [4:0]   m_depth;
    logic [W-1:0] m_top, m_second;

    always @(posedge clk) begin
        if (reset) begin
            m_depth  <= '0;
            m_top    <= '0;
            m_second <= '0;
        end else begin
            m_top <= (m_depth != 5'd0) ? mem[m_depth - 5'd1] : '0;
            if (stk_push) begin
                mem[m_depth] <= stk_push_data;
                m_depth      <= m_depth + 5'd1;
            end
            if (stk_pop) m_depth <= m_depth - 5'd1;
            if (stk_write_top) mem[m_depth - 5'd1] <= stk_write_data;
            if (stk_write_second) mem[m_depth - 5'd2] <= stk_write_data;
            if (stk_read_second) m_second <= mem[m_depth - 5'd2];
        end
    end

    assign stk_top    = m_top;
    assign stk_second = m_second;
    assign stk_depth  = m_depth;

    int checks = 0;
    int failures = 0;
    int onehot_errs = 0;
    int pop_cnt = 0;
    int push_cnt = 0;
    int retire_cnt = 0;

    always @(negedge clk) begin
        if ($countones({stk_push, stk_pop, stk_read_second, stk_write_top, stk_write_second}) > 1)
            onehot_errs++;
        if (stk_pop) pop_cnt++;
        if (stk_push) push_cnt++;
        if (retired) retire_cnt++;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the stack as a queue (back = top), outcome derived from the opcode rules.
    logic [W-1:0] ref_q[$];

    function automatic void ref_step(input logic [3:0] code, input logic [W-1:0] imm,
                                     output int lat, output logic [1:0] tc);
        int n;
        logic [W-1:0] a, b, r;
        n   = ref_q.size();
        tc  = 2'd0;
        lat = 1;
        r   = '0;
        if (code >= 4'hD) begin
            tc = 2'd3;
        end else if (code == 4'h0) begin
            lat = 1;
        end else if (code == 4'h1) begin
            if (n >= 31) tc = 2'd2;
            else begin ref_q.push_back(imm); lat = 2; end
        end else if (code == 4'h2) begin
            if (n < 1) tc = 2'd1;
            else begin void'(ref_q.pop_back()); lat = 2; end
        end else if (code == 4'h8) begin
            if (n < 1) tc = 2'd1;
            else begin ref_q[n-1] = (ref_q[n-1] == 0) ? 32'd1 : 32'd0; lat = 2; end
        end else begin
            if (n < 2) tc = 2'd1;
            else begin
                b = ref_q.pop_back();
                a = ref_q.pop_back();
                case (code)
                    4'h3: r = a + b;
                    4'h4: r = a - b;
                    4'h5: r = a & b;
                    4'h6: r = a | b;
                    4'h7: r = a ^ b;
                    4'h9: r = (a == b) ? 32'd1 : 32'd0;
                    4'hA: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    4'hB: r = (a < b) ? 32'd1 : 32'd0;
                    default: r = a << (b % 32);
                endcase
                ref_q.push_back(r);
                lat = 4;
            end
        end
    endfunction

    task automatic apply_reset();
        reset    = 1'b1;
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_q.delete();
    endtask

    // Offer one opcode, then count cycles from the acceptance edge to retired or trap.
    task automatic do_op(input logic [3:0] code, input logic [W-1:0] imm, input bit noise,
                         output int lat);
        int guard;
        guard = 0;
        while (!op_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!op_ready) begin
            failures++;
            $display("FAIL ready_wait: op_ready=%0b expected 1", op_ready);
        end
        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        @(negedge clk);
        check("ready_drop", op_ready, 0);
        op_valid = noise;
        op_code  = 4'($urandom);
        op_imm   = $urandom;
        lat = 1;
        while (!retired && !trap && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (retired) begin
            @(negedge clk);
            op_valid = 1'b0;
            check("retire_pulse", retired, 0);
            check("ready_back", op_ready, 1);
        end else begin
            op_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]   code;
        logic [W-1:0] imm;
        int           lat;
        logic [W-1:0] top;
        int           depth;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] imm, input int lat,
                                input logic [W-1:0] top, input int depth);
        vec_t v;
        v.code = c; v.imm = imm; v.lat = lat; v.top = top; v.depth = depth;
        return v;
    endfunction

    vec_t vecs[26];

    initial begin
        int lat, exp_lat, snap, n;
        logic [1:0] exp_tc;
        logic [3:0] code;

        vecs[0]  = mk(OP_CONST, 32'd5,        2, 32'd5,        1);
        vecs[1]  = mk(OP_CONST, 32'd3,        2, 32'd3,        2);
        vecs[2]  = mk(OP_SUB,   32'd0,        4, 32'd2,        1);
        vecs[3]  = mk(OP_DROP,  32'd0,        2, 32'd0,        0);
        vecs[4]  = mk(OP_CONST, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 1);
        vecs[5]  = mk(OP_CONST, 32'd1,        2, 32'd1,        2);
        vecs[6]  = mk(OP_LT_S,  32'd0,        4, 32'd1,        1);
        vecs[7]  = mk(OP_DROP,  32'd0,        2, 32'd0,        0);
        vecs[8]  = mk(OP_CONST, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 1);
        vecs[9]  = mk(OP_CONST, 32'd1,        2, 32'd1,        2);
        vecs[10] = mk(OP_LT_U,  32'd0,        4, 32'd0,        1);
        vecs[11] = mk(OP_EQZ,   32'd0,        2, 32'd1,        1);
        vecs[12] = mk(OP_NOP,   32'd0,        1, 32'd1,        1);
        vecs[13] = mk(OP_CONST, 32'h80000001, 2, 32'h80000001, 2);
        vecs[14] = mk(OP_SHL,   32'd0,        4, 32'd2,        1);
        vecs[15] = mk(OP_CONST, 32'd2,        2, 32'd2,        2);
        vecs[16] = mk(OP_EQ,    32'd0,        4, 32'd1,        1);
        vecs[17] = mk(OP_CONST, 32'h0F0F,     2, 32'h0F0F,     2);
        vecs[18] = mk(OP_XOR,   32'd0,        4, 32'h0F0E,     1);
        vecs[19] = mk(OP_CONST, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 2);
        vecs[20] = mk(OP_ADD,   32'd0,        4, 32'h0F0D,     1);
        vecs[21] = mk(OP_CONST, 32'hF0,       2, 32'hF0,       2);
        vecs[22] = mk(OP_OR,    32'd0,        4, 32'hFFD,      1);
        vecs[23] = mk(OP_CONST, 32'hFF,       2, 32'hFF,       2);
        vecs[24] = mk(OP_AND,   32'd0,        4, 32'hFD,       1);
        vecs[25] = mk(OP_EQZ,   32'd0,        2, 32'd0,        1);

        // Reset values, observed while reset is held.
        repeat (2) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ready", op_ready, 1);
        check("rst_retired", retired, 0);
        check("rst_trap", trap, 0);
        check("rst_trap_code", trap_code, 0);
        check("rst_cmds", {stk_push, stk_pop, stk_read_second, stk_write_top, stk_write_second}, 0);
        check("rst_push_data", stk_push_data, 0);
        check("rst_write_data", stk_write_data, 0);
        reset = 1'b0;

        snap = retire_cnt;
        for (int i = 0; i < 26; i++) begin
            do_op(vecs[i].code, vecs[i].imm, bit'(i % 2), lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_trap", i), trap, 0);
            check($sformatf("vec%0d_depth", i), stk_depth, W'(vecs[i].depth));
            if (vecs[i].depth > 0) check($sformatf("vec%0d_top", i), stk_top, vecs[i].top);
            if (i == 2) check("three_retired", retire_cnt - snap, 3);
        end

        // DROP on an empty stack: underflow, no pop, stays stuck.
        apply_reset();
        snap = pop_cnt;
        do_op(OP_DROP, 32'd0, 1'b0, lat);
        check("uf_lat", lat, 1);
        check("uf_trap", trap, 1);
        check("uf_code", trap_code, TRAP_UNDER);
        op_valid = 1'b1;
        op_code  = OP_CONST;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("uf_hold_ready%0d", i), op_ready, 0);
            check($sformatf("uf_hold_code%0d", i), trap_code, TRAP_UNDER);
            op_code = 4'($urandom_range(13, 15));
        end
        op_valid = 1'b0;
        check("uf_no_pop", pop_cnt - snap, 0);

        // Fill to 31 then one more CONST: overflow, depth unchanged.
        apply_reset();
        for (int i = 0; i < 31; i++) do_op(OP_CONST, W'(i + 100), 1'b0, lat);
        check("full_depth", stk_depth, 31);
        check("full_top", stk_top, 130);
        snap = push_cnt;
        do_op(OP_CONST, 32'd1, 1'b0, lat);
        check("of_trap", trap, 1);
        check("of_code", trap_code, TRAP_OVER);
        repeat (2) @(negedge clk);
        check("of_depth", stk_depth, 31);
        check("of_no_push", push_cnt - snap, 0);

        // Illegal opcode, then reset clears the trap.
        apply_reset();
        do_op(4'hE, 32'd0, 1'b0, lat);
        check("ill_trap", trap, 1);
        check("ill_code", trap_code, TRAP_ILLEGAL);
        apply_reset();
        check("ill_rst_trap", trap, 0);
        check("ill_rst_ready", op_ready, 1);
        check("ill_rst_code", trap_code, 0);

        // Reset during FETCH2 of an ADD.
        do_op(OP_CONST, 32'd11, 1'b0, lat);
        do_op(OP_CONST, 32'd22, 1'b0, lat);
        op_valid = 1'b1;
        op_code  = OP_ADD;
        @(negedge clk);
        op_valid = 1'b0;
        check("mid_fetch2", dbg_state, ST_FETCH2);
        check("mid_read2", stk_read_second, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_cmds", {stk_push, stk_pop, stk_read_second, stk_write_top, stk_write_second}, 0);
        reset = 1'b0;
        ref_q.delete();
        do_op(OP_CONST, 32'd7, 1'b0, lat);
        check("mid_c7_top", stk_top, 7);
        check("mid_c7_depth", stk_depth, 1);

        // Randomized opcodes against the queue reference.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            n = ref_q.size();
            if ($urandom_range(0, 99) < 35 || (n < 2 && $urandom_range(0, 9) != 0))
                code = OP_CONST;
            else if ($urandom_range(0, 99) < 92)
                code = 4'($urandom_range(0, 12));
            else
                code = 4'($urandom_range(13, 15));
            op_imm = $urandom;
            if ($urandom_range(0, 3) == 0) op_imm = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            begin
                logic [W-1:0] imm;
                imm = op_imm;
                ref_step(code, imm, exp_lat, exp_tc);
                do_op(code, imm, bit'($urandom_range(0, 1)), lat);
            end
            check($sformatf("rnd%0d_lat", i), lat, exp_lat);
            check($sformatf("rnd%0d_code", i), trap_code, exp_tc);
            if (exp_tc != 2'd0) begin
                check($sformatf("rnd%0d_trap", i), trap, 1);
                apply_reset();
            end else begin
                check($sformatf("rnd%0d_depth", i), stk_depth, W'(ref_q.size()));
                if (ref_q.size() > 0) check($sformatf("rnd%0d_top", i), stk_top, ref_q[ref_q.size()-1]);
            end
        end

        check("cmd_onehot", onehot_errs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
